// File: rtl/mem_arb_pkg.sv
// Shared encodings for mem_arbiter: FSM state codes, ls_size codes and transfer lengths.
package mem_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StIfRd = 2'd1;
  localparam state_t StLsRd = 2'd2;
  localparam state_t StLsWr = 2'd3;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  localparam logic [2:0] LenByte = 3'd1;
  localparam logic [2:0] LenHalf = 3'd2;
  localparam logic [2:0] LenWord = 3'd4;

  // Size code 11 falls through to a full word.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      SizeByte: return LenByte;
      SizeHalf: return LenHalf;
      default:  return LenWord;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_byte_asm.sv
// Inserts a RAM byte at lane pos_i of the accumulator and extends the result to 32 bits
// according to the transfer length, zero- or sign-filling the upper bits.
module mem_arb_byte_asm import mem_arb_pkg::*; (
  input  logic [31:0] acc_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  pos_i,
  input  logic [2:0]  len_i,
  input  logic        sext_i,
  output logic [31:0] word_o,
  output logic [31:0] ext_o
);

  always_comb begin
    word_o = acc_i;
    word_o[{pos_i, 3'b000} +: 8] = byte_i;
    case (len_i)
      LenByte: ext_o = {{24{sext_i & word_o[7]}}, word_o[7:0]};
      LenHalf: ext_o = {{16{sext_i & word_o[15]}}, word_o[15:0]};
      default: ext_o = word_o;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Byte-serial RAM arbiter between instruction fetch and load/store ports.
// Optional MEM_ARB_ROUND_ROBIN_EN alternates grants on simultaneous requests.
module mem_arbiter import mem_arb_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_i,
  input  logic        flush_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_done_o,
  output logic [31:0] if_data_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [1:0]  ls_size_i,
  input  logic        ls_signed_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_done_o,
  output logic [31:0] ls_rdata_o,
  input  logic [7:0]  mem_din_i,
  output logic [7:0]  mem_dout_o,
  output logic [31:0] mem_a_o,
  output logic        mem_wr_o
);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, n_q, n_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, acc_q, acc_d;
  logic        sext_q, sext_d;
  logic        if_done_q, if_done_d, ls_done_q, ls_done_d;
  logic [31:0] if_data_q, if_data_d, ls_rdata_q, ls_rdata_d;
  logic        grant_ls, grant_if, reading;
  logic [2:0]  off;
  logic [1:0]  pos;
  logic [31:0] asm_word, asm_ext;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // rr_last_q set means the most recent grant went to LS.
  logic rr_last_q, rr_last_d;
  assign grant_ls = ls_req_i & (~if_req_i | ~rr_last_q);

  always_comb begin
    rr_last_d = rr_last_q;
    if (state_q == StIdle && !flush_i && (ls_req_i || if_req_i)) rr_last_d = grant_ls;
  end

  always_ff @(posedge clk) begin
    if (rst)        rr_last_q <= 1'b0;
    else if (rdy_i) rr_last_q <= rr_last_d;
  end
`else
  assign grant_ls = ls_req_i;
`endif
  assign grant_if = if_req_i & ~grant_ls;

  // Byte captured at the end of a read cycle belongs to the address issued one cycle earlier.
  assign pos = 2'(cnt_q - 3'd1);

  mem_arb_byte_asm u_byte_asm (
    .acc_i  (acc_q),
    .byte_i (mem_din_i),
    .pos_i  (pos),
    .len_i  (n_q),
    .sext_i (sext_q),
    .word_o (asm_word),
    .ext_o  (asm_ext)
  );

  assign reading = (state_q == StIfRd) || (state_q == StLsRd);
  // While stalled, re-present the in-flight read address so the byte is valid on resume.
  assign off = (reading && !rdy_i) ? cnt_q - 3'd1 : cnt_q;

  always_comb begin
    mem_a_o    = '0;
    mem_dout_o = '0;
    if (state_q != StIdle && off < n_q) mem_a_o = addr_q + {29'd0, off};
    if (state_q == StLsWr) mem_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
  end

  assign mem_wr_o   = (state_q == StLsWr) & rdy_i;
  assign if_done_o  = if_done_q & rdy_i;
  assign ls_done_o  = ls_done_q & rdy_i;
  assign if_data_o  = if_data_q;
  assign ls_rdata_o = ls_rdata_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sext_d     = sext_q;
    acc_d      = acc_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!flush_i && (grant_ls || grant_if)) begin
          cnt_d = '0;
          acc_d = '0;
          if (grant_ls) begin
            state_d = ls_we_i ? StLsWr : StLsRd;
            addr_d  = ls_addr_i;
            n_d     = size_to_len(ls_size_i);
            wdata_d = ls_wdata_i;
            sext_d  = ls_signed_i;
          end else begin
            state_d = StIfRd;
            addr_d  = if_addr_i;
            n_d     = LenWord;
            wdata_d = '0;
            sext_d  = 1'b0;
          end
        end
      end
      StIfRd, StLsRd: begin
        if (flush_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q != 3'd0) acc_d = asm_word;
          if (cnt_q == n_q) begin
            state_d = StIdle;
            cnt_d   = '0;
            if (state_q == StIfRd) begin
              if_done_d = 1'b1;
              if_data_d = asm_ext;
            end else begin
              ls_done_d  = 1'b1;
              ls_rdata_d = asm_ext;
            end
          end
        end
      end
      StLsWr: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == n_q - 3'd1) begin
          state_d    = StIdle;
          cnt_d      = '0;
          ls_done_d  = 1'b1;
          ls_rdata_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      n_q        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sext_q     <= 1'b0;
      acc_q      <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else if (rdy_i) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sext_q     <= sext_d;
      acc_q      <= acc_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a byte-array RAM and a
// transaction-level model of load/store/fetch results and timing.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        if_req, ls_req, ls_we, ls_signed;
  logic [31:0] if_addr, ls_addr, ls_wdata, if_data, ls_rdata, mem_a;
  logic [1:0]  ls_size;
  logic        if_done, ls_done, mem_wr;
  logic [7:0]  mem_din, mem_dout;
  logic [7:0]  ram [256];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter u_dut (
    .clk         (clk),
    .rst         (rst),
    .rdy_i       (rdy),
    .flush_i     (flush),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_done_o   (if_done),
    .if_data_o   (if_data),
    .ls_req_i    (ls_req),
    .ls_we_i     (ls_we),
    .ls_size_i   (ls_size),
    .ls_signed_i (ls_signed),
    .ls_addr_i   (ls_addr),
    .ls_wdata_i  (ls_wdata),
    .ls_done_o   (ls_done),
    .ls_rdata_o  (ls_rdata),
    .mem_din_i   (mem_din),
    .mem_dout_o  (mem_dout),
    .mem_a_o     (mem_a),
    .mem_wr_o    (mem_wr)
  );

  // Synchronous RAM: read data appears the cycle after its address.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[7:0]];
    if (mem_wr) ram[mem_a[7:0]] = mem_dout;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int len_of(input bit ls, input logic [1:0] sz);
    if (!ls) return 4;
    case (sz)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input bit sgn);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v = v | (64'(ram[8'(a + 32'(k))]) << (8 * k));
    if (sgn && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction

  task automatic run_txn(input string tag, input bit ls, input bit we, input logic [1:0] sz,
                         input bit sgn, input logic [31:0] a, input logic [31:0] wd,
                         input int stall_at, input int stall_len, input int flush_at,
                         output logic [31:0] res);
    int n, lat, edges, wrs, bad_a, other;
    bit done, st;
    logic [31:0] exp;
    logic [7:0] after_byte;
    st = ls && we;
    n = len_of(ls, sz);
    lat = st ? n + 1 : n + 2;
    exp = st ? 32'd0 : ref_load(a, n, ls && sgn);
    after_byte = ram[8'(a + 32'(n))];
    ls_we = we; ls_size = sz; ls_signed = sgn; ls_wdata = wd;
    if (ls) begin ls_addr = a; ls_req = 1'b1; end
    else begin if_addr = a; if_req = 1'b1; end
    edges = 0; wrs = 0; bad_a = 0; other = 0; done = 1'b0; res = '0;
    while (!done && edges < 40) begin
      tick();
      edges++;
      if (mem_wr) wrs++;
      if (ls ? if_done : ls_done) other++;
      if (stall_len == 0 && edges <= n) begin
        if (mem_a !== a + 32'(edges - 1)) bad_a++;
        if (st && (mem_wr !== 1'b1 || mem_dout !== wd[8*(edges-1) +: 8])) bad_a++;
      end
      if (ls ? ls_done : if_done) begin
        done = 1'b1;
        res = ls ? ls_rdata : if_data;
        ls_req = 1'b0;
        if_req = 1'b0;
      end
      flush = (edges == flush_at);
      if (stall_len > 0 && edges == stall_at) rdy = 1'b0;
      if (stall_len > 0 && edges == stall_at + stall_len) rdy = 1'b1;
    end
    flush = 1'b0;
    rdy = 1'b1;
    check({tag, "_lat"}, 32'(edges), 32'(lat + stall_len));
    check({tag, "_data"}, res, exp);
    check({tag, "_wrs"}, 32'(wrs), st ? 32'(n) : 32'd0);
    check({tag, "_other_done"}, 32'(other), 32'd0);
    if (stall_len == 0) check({tag, "_addr_seq"}, 32'(bad_a), 32'd0);
    if (st) begin
      for (int k = 0; k < n; k++)
        check({tag, "_ram"}, 32'(ram[8'(a + 32'(k))]), 32'(wd[8*k +: 8]));
      check({tag, "_ram_beyond"}, 32'(ram[8'(a + 32'(n))]), 32'(after_byte));
    end
    tick();
    check({tag, "_pulse_end"}, 32'({if_done, ls_done}), 32'd0);
  endtask

  // Read aborted by flush at the given cycle; no done may follow.
  task automatic flush_read(input string tag, input bit ls, input logic [1:0] sz,
                            input logic [31:0] a, input int flush_at);
    int dones;
    dones = 0;
    ls_we = 1'b0; ls_size = sz; ls_signed = 1'b0;
    if (ls) begin ls_addr = a; ls_req = 1'b1; end
    else begin if_addr = a; if_req = 1'b1; end
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (if_done || ls_done) dones++;
      if (e == flush_at + 1) check({tag, "_idle"}, mem_a, 32'd0);
      flush = (e == flush_at);
      if (e == flush_at) begin ls_req = 1'b0; if_req = 1'b0; end
    end
    flush = 1'b0;
    check({tag, "_no_done"}, 32'(dones), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    int first, second, dn;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_signed = 1'b0; ls_size = 2'b10;
    if_addr = '0; ls_addr = 32'h44; ls_wdata = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
    tick();
    tick();
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_dones", 32'({if_done, ls_done}), 32'd0);
    check("rst_if_data", if_data, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    ls_req = 1'b0;
    rst = 1'b0;
    tick();

    ram[8'h00] = 8'h13; ram[8'h01] = 8'h05; ram[8'h02] = 8'h00; ram[8'h03] = 8'h00;
    run_txn("if_fetch", 1'b0, 1'b0, 2'b10, 1'b0, 32'h1000, 32'd0, 0, 0, 0, r);
    check("if_fetch_const", r, 32'h0000_0513);

    // Both requesters rise together twice; LS is served before IF each time.
    for (int rnd = 0; rnd < 2; rnd++) begin
      if_addr = 32'h1100; ls_addr = 32'h2200; ls_we = 1'b0; ls_size = 2'b10; ls_signed = 1'b0;
      if_req = 1'b1; ls_req = 1'b1;
      first = 0; second = 0;
      for (int c = 0; c < 30 && second == 0; c++) begin
        tick();
        if (c == 0) check("arb_grant", mem_a, 32'h2200);
        if (ls_done) begin if (first == 0) first = 1; else second = 1; ls_req = 1'b0; end
        if (if_done) begin if (first == 0) first = 2; else second = 2; if_req = 1'b0; end
      end
      check("arb_first", 32'(first), 32'd1);
      check("arb_second", 32'(second), 32'd2);
      ls_req = 1'b0; if_req = 1'b0;
      tick();
    end

    ram[8'h20] = 8'hFE; ram[8'h21] = 8'hFF;
    run_txn("ld_half_s", 1'b1, 1'b0, 2'b01, 1'b1, 32'h20, 32'd0, 0, 0, 0, r);
    check("ld_half_s_const", r, 32'hFFFF_FFFE);
    run_txn("ld_half_u", 1'b1, 1'b0, 2'b01, 1'b0, 32'h20, 32'd0, 0, 0, 0, r);
    check("ld_half_u_const", r, 32'h0000_FFFE);

    run_txn("st_word", 1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'hDEAD_BEEF, 0, 0, 0, r);
    check("st_word_bytes", {ram[8'h33], ram[8'h32], ram[8'h31], ram[8'h30]}, 32'hDEAD_BEEF);

    run_txn("ld_wrap", 1'b1, 1'b0, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'd0, 0, 0, 0, r);
    run_txn("ld_stall", 1'b1, 1'b0, 2'b10, 1'b0, 32'h60, 32'd0, 2, 3, 0, r);
    run_txn("st_flush", 1'b1, 1'b1, 2'b00, 1'b0, 32'h70, 32'h0000_00A5, 0, 0, 1, r);

    flush_read("if_flush", 1'b0, 2'b10, 32'h1200, 2);
    flush_read("ld_flush_last", 1'b1, 2'b01, 32'h50, 3);

    // Reset mid-load while stalled must still return to idle and clear outputs.
    ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h44; ls_req = 1'b1;
    tick();
    tick();
    rdy = 1'b0; rst = 1'b1;
    tick();
    check("rst_mid_mem_a", mem_a, 32'd0);
    check("rst_mid_rdata", ls_rdata, 32'd0);
    check("rst_mid_if_data", if_data, 32'd0);
    rst = 1'b0; rdy = 1'b1; ls_req = 1'b0;
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (ls_done || mem_a != 32'd0) dn++;
    end
    check("rst_mid_quiet", 32'(dn), 32'd0);

    for (int i = 0; i < 80; i++) begin
      bit ls, we, sgn;
      logic [1:0] sz;
      logic [31:0] a, wd;
      int n, base, sa, sl, fa;
      ls = 1'($urandom_range(0, 1));
      we = ls & 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sgn = 1'($urandom_range(0, 1));
      a = $urandom;
      if (i % 8 == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      wd = $urandom;
      n = len_of(ls, sz);
      base = (ls && we) ? n + 1 : n + 2;
      sa = 0; sl = 0; fa = 0;
      if ($urandom_range(0, 2) == 0) begin
        sl = $urandom_range(1, 3);
        sa = $urandom_range(1, base - 1);
      end
      if (ls && we && $urandom_range(0, 1) == 1) fa = $urandom_range(1, n);
      run_txn("rnd", ls, we, sz, sgn, a, wd, sa, sl, fa, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
